// File: rtl/snn_pkg.sv
// Shared SNN definitions: neuron FSM encoding and default datapath widths.
package snn_pkg;

    // Default widths shared between mac and lif_neuron
    localparam int WIDTH_DEF  = 8;
    localparam int VMEM_W_DEF = 12;

    // Neuron FSM encoding; IDLE is all-zeros so reset lands there
    typedef logic [1:0] lif_state_t;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_INTEGRATE = 2'd1;
    localparam logic [1:0] S_REFRACT   = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

endpackage

// File: rtl/lif_sat_leak_add.sv
// Combinational membrane update: v_next = sat(vmem - leak + sext(sum)).
module lif_sat_leak_add
    import snn_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int VMEM_W     = VMEM_W_DEF,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [VMEM_W-1:0] vmem_i,
    input  logic signed [WIDTH-1:0]  sum_i,
    output logic signed [VMEM_W-1:0] v_next_o
);

    logic signed [VMEM_W-1:0] leak;
    logic signed [VMEM_W:0]   sum_ext;
    logic signed [VMEM_W:0]   acc;

    // Clamp a one-bit-wider result back into the VMEM_W signed range
    function automatic logic signed [VMEM_W-1:0] sat(input logic signed [VMEM_W:0] x);
        if (x[VMEM_W] != x[VMEM_W-1]) begin
            sat = x[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}};
        end else begin
            sat = x[VMEM_W-1:0];
        end
    endfunction

    // Leak term: arithmetic shift of the potential, or nothing when disabled
    always_comb begin
        leak = '0;
        if (LEAK_SHIFT != 0) begin
            leak = vmem_i >>> LEAK_SHIFT;
        end
    end

    assign sum_ext  = {{(VMEM_W + 1 - WIDTH){sum_i[WIDTH-1]}}, sum_i};
    assign acc      = {vmem_i[VMEM_W-1], vmem_i} - {leak[VMEM_W-1], leak} + sum_ext;
    assign v_next_o = sat(acc);

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and windowed spike count.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int VMEM_W     = VMEM_W_DEF,
    parameter int THRESHOLD  = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int T_STEPS    = 16,
    parameter int CNT_W      = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [WIDTH-1:0]  sum_in,
    output logic                     in_ready,
    output logic                     spike_out,
    output logic signed [VMEM_W-1:0] vmem_out,
    output logic [CNT_W-1:0]         spike_count,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int SW = $clog2(T_STEPS + 1);
    localparam logic signed [VMEM_W-1:0] THR = VMEM_W'(THRESHOLD);

    lif_state_t               state_q, state_d;
    logic signed [VMEM_W-1:0] vmem_q, vmem_d;
    logic                     spike_q, spike_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]            step_q, step_d;
    logic [RW-1:0]            refr_q, refr_d;
    logic signed [VMEM_W-1:0] v_next;
    logic                     last_beat;

    lif_sat_leak_add #(
        .WIDTH      (WIDTH),
        .VMEM_W     (VMEM_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .vmem_i   (vmem_q),
        .sum_i    (sum_in),
        .v_next_o (v_next)
    );

    assign last_beat = (step_q == SW'(T_STEPS - 1));

    // Next-state logic: start clears and wins over a same-cycle beat
    always_comb begin
        state_d = state_q;
        vmem_d  = vmem_q;
        spike_d = 1'b0;
        cnt_d   = cnt_q;
        step_d  = step_q;
        refr_d  = refr_q;
        if (start) begin
            vmem_d  = '0;
            cnt_d   = '0;
            step_d  = '0;
            refr_d  = '0;
            state_d = S_INTEGRATE;
        end else begin
            case (state_q)
                S_INTEGRATE: begin
                    if (in_valid) begin
                        step_d = step_q + 1'b1;
                        if (v_next >= THR) begin
                            spike_d = 1'b1;
                            vmem_d  = '0;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                            refr_d = RW'(REFRAC);
                            if (REFRAC > 0) begin
                                state_d = S_REFRACT;
                            end
                        end else begin
                            vmem_d = v_next;
                        end
                        if (last_beat) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_REFRACT: begin
                    if (in_valid) begin
                        step_d = step_q + 1'b1;
                        vmem_d = '0;
                        refr_d = refr_q - 1'b1;
                        if (refr_q <= RW'(1)) begin
                            state_d = S_INTEGRATE;
                        end
                        if (last_beat) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vmem_q  <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
            step_q  <= '0;
            refr_q  <= '0;
        end else begin
            state_q <= state_d;
            vmem_q  <= vmem_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            refr_q  <= refr_d;
        end
    end

    assign busy        = (state_q == S_INTEGRATE) || (state_q == S_REFRACT);
    assign in_ready    = busy;
    assign done        = (state_q == S_DONE);
    assign spike_out   = spike_q;
    assign vmem_out    = vmem_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance plus a no-leak/no-refractory instance.
module tb_lif_neuron;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, in_valid = 1'b0;
    logic signed [7:0] sum_in = '0;
    logic              in_ready, spike_out, busy, done;
    logic signed [11:0] vmem_out;
    logic [4:0]        spike_count;

    logic              start4 = 1'b0, in_valid4 = 1'b0;
    logic signed [7:0] sum_in4 = '0;
    logic              in_ready4, spike_out4, busy4, done4;
    logic signed [11:0] vmem_out4;
    logic [4:0]        spike_count4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .sum_in(sum_in),
        .in_ready(in_ready), .spike_out(spike_out), .vmem_out(vmem_out),
        .spike_count(spike_count), .busy(busy), .done(done)
    );

    lif_neuron #(.LEAK_SHIFT(0), .REFRAC(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .sum_in(sum_in4),
        .in_ready(in_ready4), .spike_out(spike_out4), .vmem_out(vmem_out4),
        .spike_count(spike_count4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic signed [7:0] s);
        in_valid = 1'b1;
        sum_in   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic beat4(input logic signed [7:0] s);
        in_valid4 = 1'b1;
        sum_in4   = s;
        tick();
        in_valid4 = 1'b0;
    endtask

    initial begin
        // ---- Reset state ----
        #3;
        chk("rst_vmem", $signed(vmem_out), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Beats in IDLE are ignored ----
        for (int i = 0; i < 3; i++) beat(8'sd127);
        chk("idle_vmem", $signed(vmem_out), 0);
        chk("idle_spike", spike_out, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cnt", spike_count, 0);

        // ---- Async reset mid-window with in_valid high ----
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        beat(8'sd50);
        beat(8'sd50);
        chk("pre_rst_vmem", $signed(vmem_out), 94);
        in_valid = 1'b1;
        sum_in   = 8'sd50;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vmem", $signed(vmem_out), 0);
        chk("arst_busy", busy, 0);
        chk("arst_spike", spike_out, 0);
        chk("arst_cnt", spike_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("post_rst_vmem", $signed(vmem_out), 0);
        chk("post_rst_busy", busy, 0);

        // ---- Integration with leak: 30 per beat ----
        pulse_start();
        beat(8'sd30);
        chk("t2_b1_vmem", $signed(vmem_out), 30);
        beat(8'sd30);
        chk("t2_b2_vmem", $signed(vmem_out), 57);
        beat(8'sd30);
        chk("t2_b3_vmem", $signed(vmem_out), 80);
        chk("t2_b3_spike", spike_out, 0);
        beat(8'sd30);
        chk("t2_b4_spike", spike_out, 1);
        chk("t2_b4_vmem", $signed(vmem_out), 0);
        chk("t2_b4_cnt", spike_count, 1);
        beat(8'sd30);
        chk("t2_b5_spike", spike_out, 0);
        chk("t2_b5_vmem", $signed(vmem_out), 0);
        for (int i = 6; i <= 16; i++) beat(8'sd0);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_cnt", spike_count, 1);

        // ---- Saturated input with refractory: spikes on beats 1,4,...,16 ----
        pulse_start();
        for (int b = 1; b <= 16; b++) begin
            beat(8'sd127);
            chk($sformatf("t3_spike_b%0d", b), spike_out, ((b % 3) == 1) ? 1 : 0);
            chk($sformatf("t3_vmem_b%0d", b), $signed(vmem_out), 0);
            chk($sformatf("t3_done_b%0d", b), done, (b == 16) ? 1 : 0);
        end
        chk("t3_cnt", spike_count, 6);

        // ---- Beats after done are ignored, state held ----
        for (int i = 0; i < 4; i++) begin
            beat(8'sd127);
            chk("t6_done_hold", done, 0);
            chk("t6_spike_hold", spike_out, 0);
        end
        chk("t6_cnt_hold", spike_count, 6);
        chk("t6_busy", busy, 0);

        // ---- No leak, no refractory: negative accumulation to the floor ----
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int b = 1; b <= 16; b++) begin
            beat4(-8'sd128);
            chk($sformatf("t4_vmem_b%0d", b), $signed(vmem_out4), -128 * b);
            chk($sformatf("t4_spike_b%0d", b), spike_out4, 0);
        end
        chk("t4_done", done4, 1);
        beat4(-8'sd128);
        beat4(-8'sd128);
        chk("t4_vmem_hold", $signed(vmem_out4), -2048);
        chk("t4_cnt", spike_count4, 0);

        // ---- Restart mid-window; same-cycle beat dropped ----
        pulse_start();
        beat(8'sd127);
        beat(8'sd0);
        beat(8'sd0);
        beat(8'sd127);
        beat(8'sd0);
        beat(8'sd0);
        beat(8'sd0);
        beat(8'sd50);
        chk("t5_pre_cnt", spike_count, 2);
        chk("t5_pre_vmem", $signed(vmem_out), 50);
        start    = 1'b1;
        in_valid = 1'b1;
        sum_in   = 8'sd127;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_vmem", $signed(vmem_out), 0);
        chk("t5_clr_cnt", spike_count, 0);
        chk("t5_clr_spike", spike_out, 0);
        chk("t5_busy", busy, 1);
        beat(8'sd10);
        chk("t5_b1_vmem", $signed(vmem_out), 10);
        beat(8'sd10);
        beat(8'sd10);
        chk("t5_b3_vmem", $signed(vmem_out), 27);
        for (int b = 4; b <= 15; b++) beat(8'sd10);
        chk("t5_b15_done", done, 0);
        chk("t5_b15_busy", busy, 1);
        beat(8'sd10);
        chk("t5_b16_done", done, 1);
        chk("t5_cnt", spike_count, 0);
        tick();
        chk("t5_done_once", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
